// File: rtl/vga_pkg.sv
// Shared VGA-path types: scan/pixel widths, the sprite parameter bank and the
// background colour used wherever a sprite does not cover the pixel.
package vga_pkg;

    localparam int COL_W  = 10;
    localparam int ROW_W  = 9;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 12;

    localparam logic [PIX_W-1:0] COLOR_BLACK = '0;

    typedef struct packed {
        logic [COL_W-1:0]  posx;
        logic [ROW_W-1:0]  posy;
        logic [COL_W-1:0]  width;
        logic [ROW_W-1:0]  height;
        logic [ADDR_W-1:0] base;
        logic [1:0]        sx;
        logic [1:0]        sy;
        logic              mirx;
        logic              miry;
        logic              key_en;
        logic [PIX_W-1:0]  key;
    } sprite_param_t;

endpackage

// File: rtl/sprite_blit_if.sv
// Parameter-write port and sprite-memory read port of one sprite renderer.
interface sprite_blit_if;
    import vga_pkg::*;

    logic              p_we;
    logic [COL_W-1:0]  p_posx;
    logic [ROW_W-1:0]  p_posy;
    logic [COL_W-1:0]  p_width;
    logic [ROW_W-1:0]  p_height;
    logic [ADDR_W-1:0] p_base;
    logic [1:0]        p_sx;
    logic [1:0]        p_sy;
    logic              p_mirx;
    logic              p_miry;
    logic              p_key_en;
    logic [PIX_W-1:0]  p_key;
    logic              p_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;

    modport master (
        output p_we, p_posx, p_posy, p_width, p_height, p_base,
               p_sx, p_sy, p_mirx, p_miry, p_key_en, p_key, mem_data,
        input  p_busy, mem_addr
    );

    modport slave (
        input  p_we, p_posx, p_posy, p_width, p_height, p_base,
               p_sx, p_sy, p_mirx, p_miry, p_key_en, p_key, mem_data,
        output p_busy, mem_addr
    );

endinterface

// File: rtl/sprite_blit_delay_line.sv
// Fixed-depth clearable shift register used to line side-band bits up with
// the sprite memory read latency.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/sprite_blit.sv
// Single-sprite renderer: maps the scan position onto a scaled, mirrored,
// colour-keyed sprite held in external memory. Latency is MEM_LAT+3 cycles.
module sprite_blit
    import vga_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic             frame_start,
    sprite_blit_if.slave     bus,
    output logic [PIX_W-1:0] vga_data,
    output logic             opaque
);

    sprite_param_t wr_set, pending, active, cur;
    logic          busy;

    always_comb begin
        wr_set.posx   = bus.p_posx;
        wr_set.posy   = bus.p_posy;
        wr_set.width  = bus.p_width;
        wr_set.height = bus.p_height;
        wr_set.base   = bus.p_base;
        wr_set.sx     = bus.p_sx;
        wr_set.sy     = bus.p_sy;
        wr_set.mirx   = bus.p_mirx;
        wr_set.miry   = bus.p_miry;
        wr_set.key_en = bus.p_key_en;
        wr_set.key    = bus.p_key;
    end

    // The bank taking effect this cycle, so the first pixel of a frame already sees the new set.
    always_comb begin
        cur = active;
        if (frame_start) begin
            if (bus.p_we) begin
                cur = wr_set;
            end else if (busy) begin
                cur = pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= '0;
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            active <= cur;
            if (frame_start) begin
                busy <= 1'b0;
            end else if (bus.p_we) begin
                pending <= wr_set;
                busy    <= 1'b1;
            end
        end
    end

    assign bus.p_busy = busy;

    // Footprint bounds are widened by 4 bits so a sprite hanging off-screen clips instead of wrapping.
    logic [COL_W+3:0] x_lo, x_hi, col_e;
    logic [ROW_W+3:0] y_lo, y_hi, row_e;
    logic             hit;
    logic [COL_W-1:0] tx;
    logic [ROW_W-1:0] ty;

    always_comb begin
        col_e = {4'b0, col};
        row_e = {4'b0, row};
        x_lo  = {4'b0, cur.posx};
        y_lo  = {4'b0, cur.posy};
        x_hi  = x_lo + ({4'b0, cur.width} << cur.sx);
        y_hi  = y_lo + ({4'b0, cur.height} << cur.sy);
        hit   = (col_e >= x_lo) && (col_e < x_hi) && (row_e >= y_lo) && (row_e < y_hi);
        tx    = (col - cur.posx) >> cur.sx;
        ty    = (row - cur.posy) >> cur.sy;
        if (cur.mirx) begin
            tx = cur.width - tx - COL_W'(1);
        end
        if (cur.miry) begin
            ty = cur.height - ty - ROW_W'(1);
        end
    end

    logic              s1_hit;
    logic [COL_W-1:0]  s1_tx;
    logic [ROW_W-1:0]  s1_ty;
    logic [COL_W-1:0]  s1_width;
    logic [ADDR_W-1:0] s1_base;
    logic              s1_key_en;
    logic [PIX_W-1:0]  s1_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit    <= 1'b0;
            s1_tx     <= '0;
            s1_ty     <= '0;
            s1_width  <= '0;
            s1_base   <= '0;
            s1_key_en <= 1'b0;
            s1_key    <= '0;
            bus.mem_addr <= '0;
        end else begin
            s1_hit    <= hit;
            s1_tx     <= tx;
            s1_ty     <= ty;
            s1_width  <= cur.width;
            s1_base   <= cur.base;
            s1_key_en <= cur.key_en;
            s1_key    <= cur.key;
            bus.mem_addr <= s1_base + ADDR_W'(s1_ty) * ADDR_W'(s1_width) + ADDR_W'(s1_tx);
        end
    end

    logic [PIX_W+1:0] dl_in, dl_out;
    logic             d_hit, d_key_en, keyed;
    logic [PIX_W-1:0] d_key;

    assign dl_in = {s1_hit, s1_key_en, s1_key};

    delay_line #(
        .WIDTH (PIX_W + 2),
        .DEPTH (MEM_LAT + 1)
    ) u_hit_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign {d_hit, d_key_en, d_key} = dl_out;
    assign keyed = d_key_en && (bus.mem_data == d_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            opaque   <= 1'b0;
            vga_data <= COLOR_BLACK;
        end else begin
            opaque   <= d_hit && !keyed;
            vga_data <= (d_hit && !keyed) ? bus.mem_data : COLOR_BLACK;
        end
    end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: placement, scaling, mirroring, colour key,
// bank switching, reset flush and off-screen clipping / address wrap.
module tb_sprite_blit;
    import vga_pkg::*;

    localparam int MEM_LAT = 1;
    localparam int LAT     = MEM_LAT + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             frame_start;
    logic [PIX_W-1:0] vga_data;
    logic             opaque;

    int total = 0;
    int bad   = 0;

    logic             force_en  = 1'b0;
    logic [PIX_W-1:0] force_val = '0;
    logic [PIX_W-1:0] mem_q [MEM_LAT];

    sprite_blit_if bus();

    sprite_blit #(.MEM_LAT(MEM_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .frame_start (frame_start),
        .bus         (bus),
        .vga_data    (vga_data),
        .opaque      (opaque)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return force_en ? force_val : (PIX_W'(a) ^ 12'hA53);
    endfunction

    // Sprite memory stand-in with MEM_LAT cycles of read latency.
    always @(posedge clk) begin
        mem_q[0] <= mem_fn(bus.mem_addr);
        for (int i = 1; i < MEM_LAT; i++) begin
            mem_q[i] <= mem_q[i-1];
        end
    end

    assign bus.mem_data = mem_q[MEM_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(
        input logic [COL_W-1:0]  px, input logic [ROW_W-1:0] py,
        input logic [COL_W-1:0]  w,  input logic [ROW_W-1:0] h,
        input logic [ADDR_W-1:0] base,
        input logic [1:0] sx, input logic [1:0] sy,
        input logic mx, input logic my, input logic ke,
        input logic [PIX_W-1:0] key, input logic fs);
        @(negedge clk);
        bus.p_posx   = px;
        bus.p_posy   = py;
        bus.p_width  = w;
        bus.p_height = h;
        bus.p_base   = base;
        bus.p_sx     = sx;
        bus.p_sy     = sy;
        bus.p_mirx   = mx;
        bus.p_miry   = my;
        bus.p_key_en = ke;
        bus.p_key    = key;
        bus.p_we     = 1'b1;
        frame_start  = fs;
        @(negedge clk);
        bus.p_we    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Pixel held for two cycles, then an off-sprite idle pixel at (0,0).
    task automatic scanPixel(input string tag, input logic [COL_W-1:0] c, input logic [ROW_W-1:0] r,
                             input logic exp_hit, input logic exp_op, input logic [ADDR_W-1:0] exp_addr);
        logic [PIX_W-1:0] expd;
        @(negedge clk);
        col = c;
        row = r;
        repeat (2) @(negedge clk);
        if (exp_hit) checkOutput({tag, ".addr"}, 32'(bus.mem_addr), 32'(exp_addr));
        col  = '0;
        row  = '0;
        expd = exp_op ? mem_fn(exp_addr) : COLOR_BLACK;
        repeat (LAT - 2) @(negedge clk);
        checkOutput({tag, ".opaque"}, 32'(opaque), 32'(exp_op));
        checkOutput({tag, ".vga"}, 32'(vga_data), 32'(expd));
        @(negedge clk);
        checkOutput({tag, ".vga2"}, 32'(vga_data), 32'(expd));
        @(negedge clk);
        checkOutput({tag, ".tail"}, 32'(opaque), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        col = '0;
        row = '0;
        frame_start  = 1'b0;
        bus.p_we     = 1'b0;
        bus.p_posx   = '0;
        bus.p_posy   = '0;
        bus.p_width  = '0;
        bus.p_height = '0;
        bus.p_base   = '0;
        bus.p_sx     = '0;
        bus.p_sy     = '0;
        bus.p_mirx   = 1'b0;
        bus.p_miry   = 1'b0;
        bus.p_key_en = 1'b0;
        bus.p_key    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst.busy", 32'(bus.p_busy), 32'(0));
        checkOutput("rst.opaque", 32'(opaque), 32'(0));
        checkOutput("rst.vga", 32'(vga_data), 32'(0));
        checkOutput("rst.addr", 32'(bus.mem_addr), 32'(0));
        rst = 1'b0;
        scanPixel("empty", 10'd100, 9'd50, 1'b0, 1'b0, '0);

        $display("[TB] basic placement");
        applyStimulus(10'd100, 9'd50, 10'd16, 9'd8, 14'h200, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("load.busy", 32'(bus.p_busy), 32'(1));
        pulseFrame();
        checkOutput("frame.busy", 32'(bus.p_busy), 32'(0));
        scanPixel("tl", 10'd100, 9'd50, 1'b1, 1'b1, 14'h200);
        scanPixel("br", 10'd115, 9'd57, 1'b1, 1'b1, 14'h27F);
        scanPixel("left", 10'd99, 9'd50, 1'b0, 1'b0, '0);
        scanPixel("right", 10'd116, 9'd50, 1'b0, 1'b0, '0);
        scanPixel("below", 10'd100, 9'd58, 1'b0, 1'b0, '0);

        $display("[TB] scaling sx=1 sy=2");
        applyStimulus(10'd100, 9'd50, 10'd16, 9'd8, 14'h200, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        pulseFrame();
        scanPixel("sc.lastcol", 10'd131, 9'd50, 1'b1, 1'b1, 14'h20F);
        scanPixel("sc.pastcol", 10'd132, 9'd50, 1'b0, 1'b0, '0);
        scanPixel("sc.c102", 10'd102, 9'd50, 1'b1, 1'b1, 14'h201);
        scanPixel("sc.c103", 10'd103, 9'd50, 1'b1, 1'b1, 14'h201);
        scanPixel("sc.r53", 10'd100, 9'd53, 1'b1, 1'b1, 14'h200);
        scanPixel("sc.r54", 10'd100, 9'd54, 1'b1, 1'b1, 14'h210);
        scanPixel("sc.r82", 10'd100, 9'd82, 1'b0, 1'b0, '0);

        $display("[TB] horizontal mirror");
        applyStimulus(10'd100, 9'd50, 10'd16, 9'd8, 14'h200, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        pulseFrame();
        scanPixel("mir.left", 10'd100, 9'd50, 1'b1, 1'b1, 14'h20F);
        scanPixel("mir.right", 10'd115, 9'd50, 1'b1, 1'b1, 14'h200);

        $display("[TB] colour key");
        applyStimulus(10'd100, 9'd50, 10'd16, 9'd8, 14'h200, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 12'hF0F, 1'b0);
        pulseFrame();
        force_en  = 1'b1;
        force_val = 12'hF0F;
        scanPixel("key.match", 10'd100, 9'd50, 1'b1, 1'b0, 14'h200);
        force_val = 12'hF0E;
        scanPixel("key.near", 10'd100, 9'd50, 1'b1, 1'b1, 14'h200);
        force_en = 1'b0;

        $display("[TB] pending bank");
        applyStimulus(10'd200, 9'd50, 10'd16, 9'd8, 14'h200, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("pend.busy", 32'(bus.p_busy), 32'(1));
        scanPixel("pend.old", 10'd100, 9'd50, 1'b1, 1'b1, 14'h200);
        checkOutput("pend.busy2", 32'(bus.p_busy), 32'(1));
        applyStimulus(10'd300, 9'd60, 10'd16, 9'd8, 14'h100, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("pend2.busy", 32'(bus.p_busy), 32'(1));
        pulseFrame();
        checkOutput("swap.busy", 32'(bus.p_busy), 32'(0));
        scanPixel("swap.new", 10'd300, 9'd60, 1'b1, 1'b1, 14'h100);
        scanPixel("swap.first", 10'd200, 9'd50, 1'b0, 1'b0, '0);
        scanPixel("swap.old", 10'd100, 9'd50, 1'b0, 1'b0, '0);

        $display("[TB] write coincident with frame_start");
        applyStimulus(10'd400, 9'd70, 10'd16, 9'd8, 14'h300, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("coin.busy", 32'(bus.p_busy), 32'(0));
        scanPixel("coin.new", 10'd400, 9'd70, 1'b1, 1'b1, 14'h300);
        scanPixel("coin.old", 10'd300, 9'd60, 1'b0, 1'b0, '0);

        $display("[TB] reset with hits in flight");
        @(negedge clk);
        col = 10'd400;
        row = 9'd70;
        repeat (LAT) @(negedge clk);
        checkOutput("pre.opaque", 32'(opaque), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            checkOutput("flush.opaque", 32'(opaque), 32'(0));
            checkOutput("flush.vga", 32'(vga_data), 32'(0));
            @(negedge clk);
        end
        repeat (LAT) @(negedge clk);
        checkOutput("flush.nohit", 32'(opaque), 32'(0));
        checkOutput("flush.busy", 32'(bus.p_busy), 32'(0));

        $display("[TB] clipping and address wrap");
        applyStimulus(10'd1020, 9'd10, 10'd16, 9'd4, 14'h3FFE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        pulseFrame();
        scanPixel("wrap.addr", 10'd1023, 9'd11, 1'b1, 1'b1, 14'h0011);
        scanPixel("clip.nowrap", 10'd2, 9'd10, 1'b0, 1'b0, '0);
        scanPixel("clip.oldpos", 10'd400, 9'd70, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
